register_file_nr_1w_be_dift_clr: RTL and testbench
==================================================

REGISTER_FILE_NR_1W_BE_DIFT_CLR -- requirements
Module: register_file_nr_1w_be_dift_clr

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, multiple of 8; NUM_BYTE = DATA_WIDTH/8.
REQ-003 Parameter NUM_RPORTS, default 2, number of independent read ports (1..4).
REQ-004 Parameter TAG_WIDTH, default 1, DIFT tag bits per byte (1..4).
REQ-005 Parameter TAG_STICKY, default 0, tag write mode: 0 = overwrite, 1 = OR-accumulate.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 ReadEnable  in  NUM_RPORTS  per-port read request.
REQ-009 ReadAddr  in  NUM_RPORTS x ADDR_WIDTH  per-port read address.
REQ-010 ReadData  out  NUM_RPORTS x DATA_WIDTH  per-port read data.
REQ-011 ReadTag  out  NUM_RPORTS x NUM_BYTE x TAG_WIDTH  per-port, per-byte tags.
REQ-012 ReadTagAny  out  NUM_RPORTS  OR-reduction of that port's ReadTag.
REQ-013 WriteEnable  in  1  write request.
REQ-014 WriteAddr  in  ADDR_WIDTH  write address.
REQ-015 WriteData  in  NUM_BYTE x 8  write data.
REQ-016 WriteTag  in  NUM_BYTE x TAG_WIDTH  write tags.
REQ-017 WriteBE  in  NUM_BYTE  byte enables.
REQ-018 WriteReady  out  1  write accepted when high; equals NOT ClearBusy.
REQ-019 ClearReq  in  1  single-cycle pulse requesting a clear of all tags.
REQ-020 ClearBusy  out  1  high while the tag clear sweep runs.

Function
REQ-021 Read: at a rising edge with ReadEnable[p]=1, port p SHALL register ReadAddr[p]; ReadData[p]/ReadTag[p] SHALL reflect the word at the registered address combinationally; with ReadEnable[p]=0 the registered address holds.
REQ-022 Write acceptance: write accepted at edge N iff WriteEnable=1 and WriteReady=1; data, tags, address and BE are sampled at edge N; storage holds new content before edge N+1.
REQ-023 Only bytes with WriteBE[b]=1 SHALL change; WriteBE=0 accepted write SHALL change nothing.
REQ-024 TAG_STICKY=0: written byte tag := WriteTag[b]; TAG_STICKY=1: written byte tag := old tag OR WriteTag[b].
REQ-025 A read address registered at edge N+1 to the word written at edge N SHALL return the new data/tag (no stale read, no forwarding required earlier).
REQ-026 Multiple ports reading the same address SHALL return identical data and tags.
REQ-027 Clear FSM states IDLE, SWEEP; IDLE->SWEEP on ClearReq=1 at an edge; counter starts at 0.
REQ-028 SWEEP: one word per cycle, all tag bits of word[counter] set to 0, counter increments; after word NUM_WORDS-1 FSM returns to IDLE; ClearBusy high exactly NUM_WORDS cycles.
REQ-029 ClearReq during SWEEP SHALL be ignored (no restart).
REQ-030 WriteEnable while ClearBusy=1 SHALL be dropped (not queued); data contents never altered by the sweep.
REQ-031 ClearReq and accepted write at the same edge: write completes first, sweep then clears its tag.
REQ-032 Reads remain functional during SWEEP; a word already swept returns zero tags.
REQ-033 Write clock gating SHALL use cluster_clock_gating cells; functional behaviour identical to flip-flop storage.

Reset
REQ-034 rst=1 SHALL immediately: FSM to IDLE, counter 0, ClearBusy 0, WriteReady 1, all read address registers 0, all stored tags 0.
REQ-035 Data storage SHALL NOT be reset; ReadData after reset undefined until written.
REQ-036 rst during SWEEP SHALL abort the sweep; all tags 0 by REQ-034.

Verification
REQ-037 Reset, write addr 3 data 0xDEADBEEF tag 4'b0101 BE 4'hF, read port0 addr 3 next edge -> ReadData 0xDEADBEEF, ReadTag 4'b0101, ReadTagAny 1.
REQ-038 Write addr 7 0x11223344, then BE 4'b0010 data 0xAAAAAAAA -> read 0x1122AA44; port0 and port1 both at addr 7 agree.
REQ-039 TAG_STICKY=1: write tag 4'b0001 then 4'b1000 to addr 2 -> ReadTag 4'b1001; TAG_STICKY=0 -> 4'b1000.
REQ-040 ADDR_WIDTH=3, tags set in all words, ClearReq pulse -> ClearBusy high 8 cycles, write during busy dropped, all ReadTag 0 after, data unchanged.
REQ-041 rst asserted mid-sweep (cycle 3) -> ClearBusy 0 immediately, WriteReady 1, all tags 0.
REQ-042 ClearReq with same-edge write tag 1 to addr 5 -> after sweep addr 5 data new, tag 0.

Source files
------------

// File: rtl/register_file_nr_1w_be_dift_clr.sv
// Multi-read, single-write register file with per-byte DIFT tags and a
// one-word-per-cycle tag clear sweep. Data bytes sit behind gated write clocks.

module cluster_clock_gating (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);
  logic en_latch;

  // Enable is captured while clk is low so gclk never glitches.
  always_latch begin
    if (!clk) en_latch = en | test_en;
  end

  assign gclk = clk & en_latch;
endmodule

module register_file_nr_1w_be_dift_clr #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter int TAG_WIDTH  = 1,
  parameter int TAG_STICKY = 0
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [NUM_RPORTS-1:0]                                   ReadEnable,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]                   ReadAddr,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]                   ReadData,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH/8-1:0][TAG_WIDTH-1:0]  ReadTag,
  output logic [NUM_RPORTS-1:0]                                   ReadTagAny,
  input  logic                                                    WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                                   WriteAddr,
  input  logic [DATA_WIDTH/8-1:0][7:0]                            WriteData,
  input  logic [DATA_WIDTH/8-1:0][TAG_WIDTH-1:0]                  WriteTag,
  input  logic [DATA_WIDTH/8-1:0]                                 WriteBE,
  output logic                                                    WriteReady,
  input  logic                                                    ClearReq,
  output logic                                                    ClearBusy
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam int NUM_BYTE  = DATA_WIDTH/8;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                                    state;
  logic [ADDR_WIDTH-1:0]                     sweep_cnt;
  logic                                      clear_busy;
  logic                                      accept;
  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]     raddr_q;
  logic [NUM_BYTE-1:0][TAG_WIDTH-1:0]        tags [NUM_WORDS];
  logic [NUM_BYTE-1:0][7:0]                  words [NUM_WORDS];

  assign WriteReady = ~clear_busy;
  assign ClearBusy  = clear_busy;
  assign accept     = WriteEnable & ~clear_busy;

  // Clear sweep controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearReq) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            clear_busy <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Writes and the sweep never collide: writes are refused while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WORDS; w++) tags[w] <= '0;
    end else begin
      if (accept) begin
        for (int b = 0; b < NUM_BYTE; b++) begin
          if (WriteBE[b])
            tags[WriteAddr][b] <= (TAG_STICKY != 0) ? (tags[WriteAddr][b] | WriteTag[b])
                                                    : WriteTag[b];
        end
      end
      if (clear_busy) tags[sweep_cnt] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RPORTS; p++)
        if (ReadEnable[p]) raddr_q[p] <= ReadAddr[p];
    end
  end

  // One gated clock per stored byte; data is intentionally not reset.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < NUM_BYTE; b++) begin : g_byte
      logic       byte_en;
      logic       byte_clk;
      logic [7:0] byte_q;

      assign byte_en = accept && (WriteAddr == ADDR_WIDTH'(w)) && WriteBE[b];

      cluster_clock_gating u_cg (
        .clk     (clk),
        .en      (byte_en),
        .test_en (1'b0),
        .gclk    (byte_clk)
      );

      always_ff @(posedge byte_clk) byte_q <= WriteData[b];

      assign words[w][b] = byte_q;
    end
  end

  always_comb begin
    ReadData   = '0;
    ReadTag    = '0;
    ReadTagAny = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      ReadData[p]   = words[raddr_q[p]];
      ReadTag[p]    = tags[raddr_q[p]];
      ReadTagAny[p] = |tags[raddr_q[p]];
    end
  end
endmodule

// File: tb/tb_register_file_nr_1w_be_dift_clr.sv
// Directed bench: an overwrite-tag instance and a sticky-tag instance share
// every input so both tag modes are exercised by the same vectors.

module tb_register_file_nr_1w_be_dift_clr;
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       ren = '0;
  logic [1:0][2:0]  raddr = '0;
  logic [1:0][31:0] rdata, rdata_s;
  logic [1:0][3:0]  rtag, rtag_s;
  logic [1:0]       rany, rany_s;
  logic             we = 1'b0;
  logic [2:0]       waddr = '0;
  logic [31:0]      wdata = '0;
  logic [3:0]       wtag = '0;
  logic [3:0]       wbe = '0;
  logic             wready, wready_s;
  logic             creq = 1'b0;
  logic             busy, busy_s;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] data_v [8];

  always #5 clk = ~clk;

  register_file_nr_1w_be_dift_clr #(
    .ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_RPORTS(2), .TAG_WIDTH(1), .TAG_STICKY(0)
  ) dut (
    .clk(clk), .rst(rst), .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdata),
    .ReadTag(rtag), .ReadTagAny(rany), .WriteEnable(we), .WriteAddr(waddr),
    .WriteData(wdata), .WriteTag(wtag), .WriteBE(wbe), .WriteReady(wready),
    .ClearReq(creq), .ClearBusy(busy)
  );

  register_file_nr_1w_be_dift_clr #(
    .ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_RPORTS(2), .TAG_WIDTH(1), .TAG_STICKY(1)
  ) dut_s (
    .clk(clk), .rst(rst), .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdata_s),
    .ReadTag(rtag_s), .ReadTagAny(rany_s), .WriteEnable(we), .WriteAddr(waddr),
    .WriteData(wdata), .WriteTag(wtag), .WriteBE(wbe), .WriteReady(wready_s),
    .ClearReq(creq), .ClearBusy(busy_s)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] t, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wtag = t; wbe = be;
    step();
    we = 1'b0; wbe = '0;
  endtask

  task automatic do_read(input logic [2:0] a0, input logic [2:0] a1);
    ren = 2'b11; raddr[0] = a0; raddr[1] = a1;
    step();
    ren = 2'b00;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wready); end
    checks++; if (rtag !== 8'h00) begin errors++; $display("FAIL reset_tags: got %h expected 00", rtag); end
    checks++; if (rany !== 2'b00) begin errors++; $display("FAIL reset_tagany: got %b expected 00", rany); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy_s: got %b expected 0", busy_s); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read;
    do_write(3'd3, 32'hDEADBEEF, 4'b0101, 4'hF);
    do_read(3'd3, 3'd3);
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h expected deadbeef", rdata[0]); end
    checks++; if (rtag[0] !== 4'b0101) begin errors++; $display("FAIL wr_tag: got %b expected 0101", rtag[0]); end
    checks++; if (rany[0] !== 1'b1) begin errors++; $display("FAIL wr_tagany: got %b expected 1", rany[0]); end
    checks++; if (rtag_s[0] !== 4'b0101) begin errors++; $display("FAIL wr_tag_s: got %b expected 0101", rtag_s[0]); end
  endtask

  task automatic test_byte_enable;
    do_write(3'd7, 32'h11223344, 4'b0011, 4'hF);
    do_write(3'd7, 32'hAAAAAAAA, 4'b0000, 4'b0010);
    do_read(3'd7, 3'd7);
    checks++; if (rdata[0] !== 32'h1122AA44) begin errors++; $display("FAIL be_data_p0: got %h expected 1122aa44", rdata[0]); end
    checks++; if (rdata[1] !== 32'h1122AA44) begin errors++; $display("FAIL be_data_p1: got %h expected 1122aa44", rdata[1]); end
    checks++; if (rtag[0] !== 4'b0001) begin errors++; $display("FAIL be_tag_p0: got %b expected 0001", rtag[0]); end
    checks++; if (rtag[1] !== 4'b0001) begin errors++; $display("FAIL be_tag_p1: got %b expected 0001", rtag[1]); end
    checks++; if (rtag_s[0] !== 4'b0011) begin errors++; $display("FAIL be_tag_sticky: got %b expected 0011", rtag_s[0]); end
    do_write(3'd7, 32'h00000000, 4'hF, 4'b0000);
    raddr[0] = 3'd3;
    step();
    checks++; if (rdata[0] !== 32'h1122AA44) begin errors++; $display("FAIL be0_hold_data: got %h expected 1122aa44", rdata[0]); end
    checks++; if (rtag[0] !== 4'b0001) begin errors++; $display("FAIL be0_hold_tag: got %b expected 0001", rtag[0]); end
  endtask

  task automatic test_tag_mode;
    do_write(3'd2, 32'h0, 4'b0001, 4'hF);
    do_write(3'd2, 32'h0, 4'b1000, 4'hF);
    do_read(3'd2, 3'd2);
    checks++; if (rtag[0] !== 4'b1000) begin errors++; $display("FAIL tag_overwrite: got %b expected 1000", rtag[0]); end
    checks++; if (rtag_s[0] !== 4'b1001) begin errors++; $display("FAIL tag_sticky: got %b expected 1001", rtag_s[0]); end
  endtask

  task automatic test_back_to_back;
    we = 1'b1; waddr = 3'd1; wdata = 32'hA5A5A5A5; wtag = 4'b0001; wbe = 4'hF;
    step();
    waddr = 3'd0; wdata = 32'h5A5A5A5A; wtag = 4'b0000;
    ren = 2'b11; raddr[0] = 3'd1; raddr[1] = 3'd0;
    step();
    we = 1'b0; wbe = '0; ren = 2'b00;
    checks++; if (rdata[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_prev: got %h expected a5a5a5a5", rdata[0]); end
    checks++; if (rtag[0] !== 4'b0001) begin errors++; $display("FAIL b2b_prev_tag: got %b expected 0001", rtag[0]); end
    checks++; if (rdata[1] !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_same: got %h expected 5a5a5a5a", rdata[1]); end
  endtask

  task automatic test_clear;
    int cnt;
    for (int w = 0; w < 8; w++) begin
      data_v[w] = 32'hC0DE0000 | w;
      do_write(w[2:0], data_v[w], 4'hF, 4'hF);
    end
    ren = 2'b11; raddr[0] = 3'd7; raddr[1] = 3'd0; creq = 1'b1;
    step();
    ren = 2'b00; creq = 1'b0;
    cnt = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start: got %b expected 1", busy); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL clr_ready_low: got %b expected 0", wready); end
    if (busy === 1'b1) cnt++;
    we = 1'b1; waddr = 3'd4; wdata = 32'hFFFFFFFF; wtag = 4'hF; wbe = 4'hF; creq = 1'b1;
    step();
    we = 1'b0; wbe = '0; creq = 1'b0;
    if (busy === 1'b1) cnt++;
    for (int i = 2; i <= 20; i++) begin
      step();
      if (busy === 1'b1) cnt++;
      if (i == 3) begin
        checks++; if (rtag[1] !== 4'h0) begin errors++; $display("FAIL clr_swept_word: got %b expected 0000", rtag[1]); end
        checks++; if (rtag[0] !== 4'hF) begin errors++; $display("FAIL clr_pending_word: got %b expected 1111", rtag[0]); end
      end
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 8", cnt); end
    for (int w = 0; w < 8; w++) begin
      do_read(w[2:0], w[2:0]);
      checks++; if (rtag !== 8'h00 || rtag_s !== 8'h00) begin errors++; $display("FAIL clr_tag_w%0d: got %h/%h expected 00/00", w, rtag, rtag_s); end
      checks++; if (rdata[0] !== data_v[w] || rdata[1] !== data_v[w]) begin errors++; $display("FAIL clr_data_w%0d: got %h/%h expected %h", w, rdata[0], rdata[1], data_v[w]); end
    end
  endtask

  task automatic test_clear_with_write;
    bit done;
    creq = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 32'h55AA55AA; wtag = 4'hF; wbe = 4'hF;
    ren = 2'b01; raddr[0] = 3'd5;
    step();
    creq = 1'b0; we = 1'b0; wbe = '0; ren = 2'b00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cw_busy: got %b expected 1", busy); end
    checks++; if (rtag[0] !== 4'hF) begin errors++; $display("FAIL cw_tag_written: got %b expected 1111", rtag[0]); end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (busy === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL cw_timeout: busy=%b expected 0 within 20 cycles", busy); end
    checks++; if (rdata[0] !== 32'h55AA55AA) begin errors++; $display("FAIL cw_data: got %h expected 55aa55aa", rdata[0]); end
    checks++; if (rtag[0] !== 4'h0 || rtag_s[0] !== 4'h0) begin errors++; $display("FAIL cw_tag_cleared: got %b/%b expected 0000", rtag[0], rtag_s[0]); end
  endtask

  task automatic test_reset_mid_sweep;
    do_write(3'd1, data_v[1], 4'hF, 4'hF);
    do_write(3'd6, data_v[6], 4'hF, 4'hF);
    ren = 2'b11; raddr[0] = 3'd6; raddr[1] = 3'd1; creq = 1'b1;
    step();
    ren = 2'b00; creq = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy_before: got %b expected 1", busy); end
    checks++; if (rtag[0] !== 4'hF) begin errors++; $display("FAIL rs_tag_before: got %b expected 1111", rtag[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL rs_busy: got %b/%b expected 0", busy, busy_s); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL rs_ready: got %b expected 1", wready); end
    checks++; if (rdata[0] !== data_v[0]) begin errors++; $display("FAIL rs_raddr_zero: got %h expected %h", rdata[0], data_v[0]); end
    checks++; if (rtag !== 8'h00) begin errors++; $display("FAIL rs_tags_now: got %h expected 00", rtag); end
    @(posedge clk);
    #1 rst = 1'b0;
    do_read(3'd6, 3'd1);
    checks++; if (rtag[0] !== 4'h0 || rtag_s[0] !== 4'h0) begin errors++; $display("FAIL rs_tag_w6: got %b/%b expected 0000", rtag[0], rtag_s[0]); end
    checks++; if (rtag[1] !== 4'h0) begin errors++; $display("FAIL rs_tag_w1: got %b expected 0000", rtag[1]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_tag_mode();
    test_back_to_back();
    test_clear();
    test_clear_with_write();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, bench did not complete", $time);
    $fatal(1);
  end
endmodule
